// File: rtl/uberclock_adc_pkg.sv
// ---------------------------------------------------------------------------
// uberclock_adc_pkg
// Shared definitions for the ADC capture path:
//   SAMPLE_W : default ADC sample width in bits
//   state_t  : capture FSM state encoding
//   pair_t   : one stored sample pair, packed as {ch1, ch0}
// ---------------------------------------------------------------------------
package uberclock_adc_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] ch1;
    logic signed [SAMPLE_W-1:0] ch0;
  } pair_t;

endpackage

// File: rtl/adc_capture_buf_if.sv
// ---------------------------------------------------------------------------
// adc_capture_buf_if
// Control/status bus between the SoC CSR block and the capture buffer.
//   arm, abort, sw_trig : single-cycle command pulses
//   trig_level          : signed ch0 threshold for the level trigger
//   cap_len, decim      : acquisition length (pairs) and decimation
//   rd_addr / rd_data   : buffer read port, 1-cycle registered latency
//   busy, done, wr_count: acquisition status
// Modports: master = SoC side, slave = capture buffer.
// ---------------------------------------------------------------------------
interface adc_capture_buf_if #(
  parameter int SAMPLE_W = uberclock_adc_pkg::SAMPLE_W,
  parameter int AW       = 10
);

  logic                       arm;
  logic                       abort;
  logic                       sw_trig;
  logic signed [SAMPLE_W-1:0] trig_level;
  logic [AW:0]                cap_len;
  logic [7:0]                 decim;
  logic [AW-1:0]              rd_addr;
  logic [2*SAMPLE_W-1:0]      rd_data;
  logic                       busy;
  logic                       done;
  logic [AW:0]                wr_count;

  modport master (
    output arm, abort, sw_trig, trig_level, cap_len, decim, rd_addr,
    input  rd_data, busy, done, wr_count
  );

  modport slave (
    input  arm, abort, sw_trig, trig_level, cap_len, decim, rd_addr,
    output rd_data, busy, done, wr_count
  );

endinterface

// File: rtl/capture_ram.sv
// ---------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample store: one write port, one registered read port,
// read-first behaviour on a same-address collision. Written so that
// synthesis maps it onto block RAM.
// Ports:
//   clk_i   : clock
//   rst_ni  : async active-low reset, clears only the read register
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, valid one cycle after raddr_i
// ---------------------------------------------------------------------------
module capture_ram #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the array sees the pre-write contents on a
  // collision, giving read-first semantics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture_buf.sv
// ---------------------------------------------------------------------------
// adc_capture_buf
// Triggered two-channel ADC capture buffer. An arm pulse latches the length
// and decimation and waits for a trigger; the trigger-cycle pair goes to
// address 0 and every (decim+1)-th pair after it is stored until cap_len
// pairs are written. Contents are readable at any time through rd_addr.
//
// Optional feature macro: ADC_CAPTURE_LEVEL_TRIG_EN
//   defined   : rising ch0 crossing of trig_level also triggers in ARMED
//   undefined : only sw_trig triggers, no comparator is built
//
// Ports:
//   sys_clk  : sole clock
//   rst_n    : asynchronous active-low reset
//   adc_ch0  : channel-0 sample (two's complement)
//   adc_ch1  : channel-1 sample (two's complement)
//   csr      : control/status bus (adc_capture_buf_if.slave)
// ---------------------------------------------------------------------------
module adc_capture_buf #(
  parameter int DEPTH    = 1024,
  parameter int SAMPLE_W = uberclock_adc_pkg::SAMPLE_W,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] adc_ch0,
  input  logic signed [SAMPLE_W-1:0] adc_ch1,
  adc_capture_buf_if.slave           csr
);

  import uberclock_adc_pkg::*;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  // Zero or an oversize request both mean "fill the whole buffer".
  function automatic logic [AW:0] eff_len(input logic [AW:0] req);
    if ((req == '0) || (req > DEPTH_L)) begin
      return DEPTH_L;
    end
    return req;
  endfunction

  state_t                state_q, state_d;
  logic [AW:0]           len_q, len_d;
  logic [7:0]            decim_q, decim_d;
  logic [7:0]            dcnt_q, dcnt_d;
  logic [AW:0]           wr_count_q, wr_count_d;
  logic [AW:0]           wr_next;
  logic                  we;
  logic                  trig;
  logic [2*SAMPLE_W-1:0] rd_data;

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  logic signed [SAMPLE_W-1:0] prev_ch0_q;
  logic                       level_evt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ch0_q <= '0;
    end else begin
      prev_ch0_q <= adc_ch0;
    end
  end

  // Rising crossing: previous sample below the threshold, current at/above.
  assign level_evt = (prev_ch0_q < csr.trig_level) && (adc_ch0 >= csr.trig_level);
  assign trig      = csr.sw_trig | level_evt;
`else
  logic unused_trig_level;
  assign unused_trig_level = ^csr.trig_level;
  assign trig              = csr.sw_trig;
`endif

  assign wr_next = wr_count_q + ONE_L;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    decim_d    = decim_q;
    dcnt_d     = dcnt_q;
    wr_count_d = wr_count_q;
    we         = 1'b0;
    if (csr.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (csr.arm) begin
            state_d    = ST_ARMED;
            len_d      = eff_len(csr.cap_len);
            decim_d    = csr.decim;
            dcnt_d     = '0;
            wr_count_d = '0;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          // The trigger cycle behaves as the first capture cycle: the
          // decimation counter is still 0 from arming, so it writes addr 0.
          if ((state_q == ST_CAPTURE) || trig) begin
            if (dcnt_q == '0) begin
              we         = 1'b1;
              wr_count_d = wr_next;
              state_d    = (wr_next == len_q) ? ST_DONE : ST_CAPTURE;
            end else begin
              state_d = ST_CAPTURE;
            end
            dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= DEPTH_L;
      decim_q    <= '0;
      dcnt_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      decim_q    <= decim_d;
      dcnt_q     <= dcnt_d;
      wr_count_q <= wr_count_d;
    end
  end

  // wr_count never reaches len (<= DEPTH) while writing, so the low AW
  // bits are always a valid, non-wrapping address.
  capture_ram #(
    .AW (AW),
    .DW (2*SAMPLE_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .we_i    (we),
    .waddr_i (wr_count_q[AW-1:0]),
    .wdata_i ({adc_ch1, adc_ch0}),
    .raddr_i (csr.rd_addr),
    .rdata_o (rd_data)
  );

  assign csr.rd_data  = rd_data;
  assign csr.busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign csr.done     = (state_q == ST_DONE);
  assign csr.wr_count = wr_count_q;

endmodule
